// File: rtl/round_judge_pkg.sv
// Shared types and constants for the not-not game: key width, colour indices,
// answer mask type and the round judge state encoding.
package not_not_pkg;

    localparam int KEY_W = 4;

    localparam int COL_0 = 0;
    localparam int COL_1 = 1;
    localparam int COL_2 = 2;
    localparam int COL_3 = 3;

    typedef logic [KEY_W-1:0] mask_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CHAL = 3'd1,
        ARM       = 3'd2,
        PLAY      = 3'd3,
        OVER      = 3'd4
    } state_t;

    function automatic logic is_onehot(mask_t m);
        return (m != '0) && ((m & (m - mask_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/round_judge_if.sv
// Challenge handshake between the challenge generator (master) and the
// round judge (slave); the generator holds valid/mask until acked.
interface round_judge_if;
    import not_not_pkg::*;

    logic  challenge_valid;
    mask_t answer_mask;
    logic  challenge_ack;

    modport master (
        output challenge_valid,
        output answer_mask,
        input  challenge_ack
    );

    modport slave (
        input  challenge_valid,
        input  answer_mask,
        output challenge_ack
    );

endinterface

// File: rtl/round_judge_key_edge_sync.sv
// Two-flop synchroniser for asynchronous level inputs plus a rising-edge
// detector on the synchronised level.
module key_edge_sync #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/round_judge.sv
// Player-side answer checker: consumes challenges, times each round,
// judges the player's key press and keeps the score.
module round_judge
    import not_not_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int SCORE_W        = 8,
    parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    round_judge_if.slave       chal,
    input  logic [KEY_W-1:0]   key_in,
    output logic               draw_req,
    output logic               round_win,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [TIMER_W-1:0] time_left,
    output logic [2:0]         state_dbg
);

    state_t             state;
    mask_t              mask_q;
    logic [TIMER_W-1:0] timer_q;
    logic [SCORE_W-1:0] score_q;
    logic               ack_q;
    logic               win_q;
    logic               over_q;

    mask_t key_s;
    mask_t press;
    logic  start_lvl_unused;
    logic  start_rise;

    key_edge_sync #(.W(KEY_W)) u_key_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (key_in),
        .level  (key_s),
        .rise   (press)
    );

    key_edge_sync #(.W(1)) u_start_sync (
        .clock  (clock),
        .resetn (resetn),
        .din    (start),
        .level  (start_lvl_unused),
        .rise   (start_rise)
    );

    // A press only counts in PLAY and beats a coincident timeout.
    logic verdict_valid;
    logic verdict_win;

    always_comb begin
        verdict_valid = 1'b0;
        verdict_win   = 1'b0;
        if (state == PLAY && press != '0) begin
            verdict_valid = 1'b1;
            verdict_win   = is_onehot(press) && ((press & mask_q) != '0);
        end else if ((state == ARM || state == PLAY) && timer_q == '0) begin
            verdict_valid = 1'b1;
            verdict_win   = (mask_q == '0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            mask_q  <= '0;
            timer_q <= '0;
            score_q <= '0;
            ack_q   <= 1'b0;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            win_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_rise) begin
                        score_q <= '0;
                        state   <= WAIT_CHAL;
                    end
                end
                WAIT_CHAL: begin
                    if (chal.challenge_valid) begin
                        mask_q  <= chal.answer_mask;
                        timer_q <= TIMER_W'(TIMEOUT_CYCLES - 1);
                        ack_q   <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM, PLAY: begin
                    if (verdict_valid) begin
                        if (verdict_win) begin
                            if (score_q != '1) begin
                                score_q <= score_q + SCORE_W'(1);
                            end
                            win_q   <= 1'b1;
                            timer_q <= '0;
                            state   <= WAIT_CHAL;
                        end else begin
                            over_q <= 1'b1;
                            state  <= OVER;
                        end
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                        if (state == ARM && key_s == '0) begin
                            state <= PLAY;
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        score_q <= '0;
                        over_q  <= 1'b0;
                        timer_q <= '0;
                        state   <= WAIT_CHAL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign chal.challenge_ack = ack_q;
    assign draw_req           = ack_q;
    assign round_win          = win_q;
    assign game_over          = over_q;
    assign score              = score_q;
    assign time_left          = timer_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with a 16-cycle round and 2-bit score.
module tb_round_judge;
    import not_not_pkg::*;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [3:0] key_in;
    logic       draw_req;
    logic       round_win;
    logic       game_over;
    logic [1:0] score;
    logic [3:0] time_left;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int draw_cnt = 0;
    int split_cnt = 0;

    round_judge_if chal_if ();

    round_judge #(.TIMEOUT_CYCLES(16), .SCORE_W(2)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .chal      (chal_if.slave),
        .key_in    (key_in),
        .draw_req  (draw_req),
        .round_win (round_win),
        .game_over (game_over),
        .score     (score),
        .time_left (time_left),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (chal_if.challenge_ack === 1'b1) ack_cnt++;
        if (draw_req === 1'b1) draw_cnt++;
        if (draw_req !== chal_if.challenge_ack) split_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        start = 1'b1;
        step(2);
        start = 1'b0;
        step(1);
    endtask

    task automatic offer(input logic [3:0] m);
        chal_if.challenge_valid = 1'b1;
        chal_if.answer_mask     = m;
        step(1);
        chal_if.challenge_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(2);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
        checks++; if (score !== 2'd0) begin errors++; $display("FAIL rst_score: got %0d expected 0", score); end
        checks++; if (time_left !== 4'd0) begin errors++; $display("FAIL rst_time: got %0d expected 0", time_left); end
        checks++; if ({game_over, round_win, draw_req, chal_if.challenge_ack} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b expected 0000", {game_over, round_win, draw_req, chal_if.challenge_ack}); end
        resetn = 1'b1;
        step(2);
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state_dbg); end
    endtask

    task automatic test_basic_win();
        start_game();
        checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL t1_wait: got %0d expected 1", state_dbg); end
        offer(4'b0100);
        checks++; if (chal_if.challenge_ack !== 1'b1 || draw_req !== 1'b1) begin errors++; $display("FAIL t1_ack: got %b%b expected 11", chal_if.challenge_ack, draw_req); end
        checks++; if (time_left !== 4'd15) begin errors++; $display("FAIL t1_load: got %0d expected 15", time_left); end
        checks++; if (state_dbg !== 3'd2) begin errors++; $display("FAIL t1_arm: got %0d expected 2", state_dbg); end
        key_in = 4'b0100;
        step(2);
        checks++; if (round_win !== 1'b0 || state_dbg !== 3'd3) begin errors++; $display("FAIL t1_early: got win=%b state=%0d expected win=0 state=3", round_win, state_dbg); end
        step(1);
        key_in = 4'b0000;
        checks++; if (round_win !== 1'b1) begin errors++; $display("FAIL t1_win: got %b expected 1", round_win); end
        checks++; if (score !== 2'd1) begin errors++; $display("FAIL t1_score: got %0d expected 1", score); end
        checks++; if (state_dbg !== 3'd1 || time_left !== 4'd0) begin errors++; $display("FAIL t1_next: got state=%0d time=%0d expected 1/0", state_dbg, time_left); end
        step(1);
        checks++; if (round_win !== 1'b0) begin errors++; $display("FAIL t1_pulse: got %b expected 0", round_win); end
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL t1_ackcnt: got %0d expected 1", ack_cnt); end
    endtask

    task automatic test_wrong_key();
        step(3);
        offer(4'b0100);
        key_in = 4'b0001;
        step(3);
        checks++; if (game_over !== 1'b1 || state_dbg !== 3'd4) begin errors++; $display("FAIL t2_over: got go=%b state=%0d expected 1/4", game_over, state_dbg); end
        checks++; if (round_win !== 1'b0) begin errors++; $display("FAIL t2_nowin: got %b expected 0", round_win); end
        checks++; if (score !== 2'd1) begin errors++; $display("FAIL t2_score: got %0d expected 1", score); end
        checks++; if (time_left !== 4'd13) begin errors++; $display("FAIL t2_time: got %0d expected 13", time_left); end
        key_in = 4'b0000;
        chal_if.challenge_valid = 1'b1;
        chal_if.answer_mask     = 4'b0010;
        step(3);
        chal_if.challenge_valid = 1'b0;
        checks++; if (ack_cnt !== 2 || state_dbg !== 3'd4) begin errors++; $display("FAIL t2_ignore: got acks=%0d state=%0d expected 2/4", ack_cnt, state_dbg); end
        checks++; if (time_left !== 4'd13) begin errors++; $display("FAIL t2_hold: got %0d expected 13", time_left); end
        start_game();
        checks++; if (score !== 2'd0 || state_dbg !== 3'd1) begin errors++; $display("FAIL t2_restart: got score=%0d state=%0d expected 0/1", score, state_dbg); end
        checks++; if (game_over !== 1'b0 || time_left !== 4'd0) begin errors++; $display("FAIL t2_clear: got go=%b time=%0d expected 0/0", game_over, time_left); end
    endtask

    task automatic test_empty_mask();
        step(3);
        offer(4'b0000);
        step(15);
        checks++; if (time_left !== 4'd0 || round_win !== 1'b0 || state_dbg !== 3'd3) begin errors++; $display("FAIL t3_zero: got time=%0d win=%b state=%0d expected 0/0/3", time_left, round_win, state_dbg); end
        step(1);
        checks++; if (round_win !== 1'b1 || score !== 2'd1) begin errors++; $display("FAIL t3_timeout_win: got win=%b score=%0d expected 1/1", round_win, score); end
        step(3);
        offer(4'b0000);
        key_in = 4'b1000;
        step(3);
        key_in = 4'b0000;
        checks++; if (game_over !== 1'b1 || score !== 2'd1) begin errors++; $display("FAIL t3_press_lose: got go=%b score=%0d expected 1/1", game_over, score); end
        start_game();
    endtask

    task automatic test_multi_and_coincide();
        step(3);
        offer(4'b1011);
        key_in = 4'b0011;
        step(3);
        key_in = 4'b0000;
        checks++; if (game_over !== 1'b1 || round_win !== 1'b0) begin errors++; $display("FAIL t4_multi: got go=%b win=%b expected 1/0", game_over, round_win); end
        start_game();
        step(3);
        offer(4'b1011);
        step(13);
        key_in = 4'b0010;
        step(2);
        checks++; if (time_left !== 4'd0 || state_dbg !== 3'd3 || round_win !== 1'b0) begin errors++; $display("FAIL t4_edge: got time=%0d state=%0d win=%b expected 0/3/0", time_left, state_dbg, round_win); end
        step(1);
        key_in = 4'b0000;
        checks++; if (round_win !== 1'b1 || game_over !== 1'b0 || score !== 2'd1) begin errors++; $display("FAIL t4_priority: got win=%b go=%b score=%0d expected 1/0/1", round_win, game_over, score); end
    endtask

    task automatic test_held_key();
        step(3);
        key_in = 4'b0100;
        step(3);
        offer(4'b0100);
        step(4);
        checks++; if (state_dbg !== 3'd2 || round_win !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL t5_arm: got state=%0d win=%b go=%b expected 2/0/0", state_dbg, round_win, game_over); end
        checks++; if (time_left !== 4'd11) begin errors++; $display("FAIL t5_armtime: got %0d expected 11", time_left); end
        key_in = 4'b0000;
        step(3);
        checks++; if (state_dbg !== 3'd3 || time_left !== 4'd8) begin errors++; $display("FAIL t5_play: got state=%0d time=%0d expected 3/8", state_dbg, time_left); end
        key_in = 4'b0100;
        step(3);
        key_in = 4'b0000;
        checks++; if (round_win !== 1'b1 || score !== 2'd2) begin errors++; $display("FAIL t5_win: got win=%b score=%0d expected 1/2", round_win, score); end
        checks++; if (ack_cnt !== 7 || draw_cnt !== 7 || split_cnt !== 0) begin errors++; $display("FAIL t5_pulses: got ack=%0d draw=%0d split=%0d expected 7/7/0", ack_cnt, draw_cnt, split_cnt); end
    endtask

    task automatic test_saturate_and_abort();
        logic [1:0] exp_score;
        step(3);
        offer(4'b0001);
        key_in = 4'b0010;
        step(3);
        key_in = 4'b0000;
        start_game();
        for (int i = 0; i < 4; i++) begin
            exp_score = (i < 3) ? 2'(i + 1) : 2'd3;
            step(3);
            offer(4'b0001);
            key_in = 4'b0001;
            step(3);
            key_in = 4'b0000;
            checks++; if (round_win !== 1'b1 || score !== exp_score) begin errors++; $display("FAIL t6_win%0d: got win=%b score=%0d expected 1/%0d", i, round_win, score, exp_score); end
        end
        step(3);
        offer(4'b0001);
        step(1);
        checks++; if (state_dbg !== 3'd3 || time_left !== 4'd14) begin errors++; $display("FAIL t6_play: got state=%0d time=%0d expected 3/14", state_dbg, time_left); end
        resetn = 1'b0;
        #2;
        checks++; if (state_dbg !== 3'd0 || score !== 2'd0 || time_left !== 4'd0) begin errors++; $display("FAIL t6_async: got state=%0d score=%0d time=%0d expected 0/0/0", state_dbg, score, time_left); end
        checks++; if ({game_over, round_win, draw_req, chal_if.challenge_ack} !== 4'b0) begin errors++; $display("FAIL t6_async_out: got %b expected 0000", {game_over, round_win, draw_req, chal_if.challenge_ack}); end
        step(1);
        resetn = 1'b1;
        step(3);
        checks++; if (state_dbg !== 3'd0 || round_win !== 1'b0) begin errors++; $display("FAIL t6_after: got state=%0d win=%b expected 0/0", state_dbg, round_win); end
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        key_in = 4'b0000;
        chal_if.challenge_valid = 1'b0;
        chal_if.answer_mask = 4'b0000;
        test_reset();
        test_basic_win();
        test_wrong_key();
        test_empty_mask();
        test_multi_and_coincide();
        test_held_key();
        test_saturate_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
